// File: rtl/accel_spi_sequencer.sv
// ADXL362 transaction scheduler: one config write, then periodic X/Y reads via a byte engine.
// Optional define ACCEL_SEQ_AVG_EN publishes (previous + new) >> 1 instead of raw samples.
module accel_spi_sequencer #(
  parameter int unsigned INIT_DELAY  = 30000,
  parameter int unsigned POLL_CYCLES = 50000,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic       spi_clk,
  input  logic       rst,
  output logic       byte_req,
  output logic [7:0] byte_tx,
  input  logic       byte_done,
  input  logic [7:0] byte_rx,
  output logic       csn,
  output logic [7:0] accel_data_x,
  output logic [7:0] accel_data_y,
  output logic       data_valid,
  output logic       init_done
);

  localparam logic [15:0] LP_INIT_LAST = 16'(INIT_DELAY - 1);
  localparam logic [15:0] LP_GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [15:0] LP_POLL_LAST = 16'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_PWR, W_CMD, W_ADDR, W_DATA, GAP, IDLE, R_CMD, R_ADDR, R_X, R_Y
  } state_t;

  state_t      r_state, w_state_n, w_byte_next;
  logic [15:0] r_timer, w_timer_n, r_poll_cnt, w_poll_cnt_n;
  logic        r_poll_pending, w_poll_pending_n;
  logic        r_req, w_req_n, r_csn, w_csn_n;
  logic        r_valid, w_valid_n, r_init_done, w_init_done_n;
  logic [7:0]  r_tx, w_tx_n, r_x, w_x_n, r_y, w_y_n;
  logic [7:0]  w_pub_x, w_pub_y, w_byte_val;
  logic        w_is_byte, w_tick, w_accept;

  assign w_accept = r_req & byte_done;
  assign w_tick   = r_init_done & (r_poll_cnt == LP_POLL_LAST);

`ifdef ACCEL_SEQ_AVG_EN
  logic r_have, w_have_n;

  always_comb begin
    w_pub_x  = r_have ? 8'((9'(r_x) + 9'(byte_rx)) >> 1) : byte_rx;
    w_pub_y  = r_have ? 8'((9'(r_y) + 9'(byte_rx)) >> 1) : byte_rx;
    w_have_n = r_have | (w_accept & (r_state == R_Y));
  end

  always_ff @(posedge spi_clk) begin
    if (rst) r_have <= 1'b0;
    else     r_have <= w_have_n;
  end
`else
  always_comb begin
    w_pub_x = byte_rx;
    w_pub_y = byte_rx;
  end
`endif

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      r_state        <= WAIT_PWR;
      r_timer        <= '0;
      r_poll_cnt     <= '0;
      r_poll_pending <= 1'b0;
      r_req          <= 1'b0;
      r_tx           <= '0;
      r_csn          <= 1'b1;
      r_x            <= '0;
      r_y            <= '0;
      r_valid        <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_timer        <= w_timer_n;
      r_poll_cnt     <= w_poll_cnt_n;
      r_poll_pending <= w_poll_pending_n;
      r_req          <= w_req_n;
      r_tx           <= w_tx_n;
      r_csn          <= w_csn_n;
      r_x            <= w_x_n;
      r_y            <= w_y_n;
      r_valid        <= w_valid_n;
      r_init_done    <= w_init_done_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_timer_n        = r_timer;
    w_req_n          = r_req;
    w_tx_n           = r_tx;
    w_csn_n          = r_csn;
    w_x_n            = r_x;
    w_y_n            = r_y;
    w_valid_n        = 1'b0;
    w_init_done_n    = r_init_done;
    w_is_byte        = 1'b0;
    w_byte_val       = '0;
    w_byte_next      = r_state;
    w_poll_cnt_n     = r_poll_cnt;
    w_poll_pending_n = r_poll_pending;

    case (r_state)
      WAIT_PWR: begin
        if (r_timer == LP_INIT_LAST) begin
          w_state_n = W_CMD;
          w_timer_n = '0;
          w_csn_n   = 1'b0;
        end else begin
          w_timer_n = r_timer + 16'd1;
        end
      end
      W_CMD:  begin w_is_byte = 1'b1; w_byte_val = 8'h0A; w_byte_next = W_ADDR; end
      W_ADDR: begin w_is_byte = 1'b1; w_byte_val = 8'h2D; w_byte_next = W_DATA; end
      W_DATA: begin w_is_byte = 1'b1; w_byte_val = 8'h02; w_byte_next = GAP;    end
      GAP: begin
        if (r_timer == LP_GAP_LAST) begin
          w_state_n = IDLE;
          w_timer_n = '0;
        end else begin
          w_timer_n = r_timer + 16'd1;
        end
      end
      IDLE: begin
        if (r_poll_pending) begin
          w_state_n = R_CMD;
          w_csn_n   = 1'b0;
        end
      end
      R_CMD:  begin w_is_byte = 1'b1; w_byte_val = 8'h0B; w_byte_next = R_ADDR; end
      R_ADDR: begin w_is_byte = 1'b1; w_byte_val = 8'h08; w_byte_next = R_X;    end
      R_X:    begin w_is_byte = 1'b1; w_byte_val = 8'h00; w_byte_next = R_Y;    end
      R_Y:    begin w_is_byte = 1'b1; w_byte_val = 8'h00; w_byte_next = GAP;    end
      default: w_state_n = WAIT_PWR;
    endcase

    // Each byte state: raise req with the byte, then advance on done; req drops for one cycle between bytes.
    if (w_is_byte) begin
      if (!r_req) begin
        w_req_n = 1'b1;
        w_tx_n  = w_byte_val;
      end else if (byte_done) begin
        w_req_n   = 1'b0;
        w_state_n = w_byte_next;
        case (r_state)
          W_DATA: begin w_init_done_n = 1'b1; w_csn_n = 1'b1; end
          R_X:    w_x_n = w_pub_x;
          R_Y:    begin w_y_n = w_pub_y; w_valid_n = 1'b1; w_csn_n = 1'b1; end
          default: ;
        endcase
      end
    end

    if (r_init_done) w_poll_cnt_n = w_tick ? '0 : r_poll_cnt + 16'd1;

    // A tick wins over consumption, so ticks collapse into one pending read.
    if (w_tick)                               w_poll_pending_n = 1'b1;
    else if (r_state == IDLE && r_poll_pending) w_poll_pending_n = 1'b0;
  end

  assign byte_req     = r_req;
  assign byte_tx      = r_tx;
  assign csn          = r_csn;
  assign accel_data_x = r_x;
  assign accel_data_y = r_y;
  assign data_valid   = r_valid;
  assign init_done    = r_init_done;

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer with a byte-engine model and an X/Y scoreboard.
module tb_accel_spi_sequencer;

  localparam int unsigned INIT_DELAY  = 10;
  localparam int unsigned POLL_CYCLES = 16;
  localparam int unsigned CS_GAP      = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_req;
  logic [7:0] byte_tx;
  logic       byte_done;
  logic [7:0] byte_rx;
  logic       csn;
  logic [7:0] ax, ay;
  logic       dv, init_done;

  always #5 clk = ~clk;

  accel_spi_sequencer #(
    .INIT_DELAY (INIT_DELAY),
    .POLL_CYCLES(POLL_CYCLES),
    .CS_GAP     (CS_GAP)
  ) dut (
    .spi_clk     (clk),
    .rst         (rst),
    .byte_req    (byte_req),
    .byte_tx     (byte_tx),
    .byte_done   (byte_done),
    .byte_rx     (byte_rx),
    .csn         (csn),
    .accel_data_x(ax),
    .accel_data_y(ay),
    .data_valid  (dv),
    .init_done   (init_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model state
  int         lat = 3;
  bit         stall_arm = 0, stalling = 0, spur_arm = 0;
  logic [7:0] rx_x = 8'h00, rx_y = 8'h00;
  bit         busy = 0, done_sent = 0;
  int         cnt = 0, idx = 0;
  logic [7:0] cur_tx, first_tx = 8'h00, rsp, smp_x;
  logic [7:0] obs_tx[$];
  logic [15:0] exp_q[$];
  bit         m_have = 0;
  logic [7:0] m_px = 8'h00, m_py = 8'h00;
  int         dv_count = 0;
  logic       dv_prev = 1'b0;

  function automatic logic [7:0] model_pub(input logic [7:0] prev, input logic [7:0] smp, input bit have);
    logic [8:0] s;
    s = {1'b0, prev} + {1'b0, smp};
`ifdef ACCEL_SEQ_AVG_EN
    return have ? s[8:1] : smp;
`else
    return (have && s[0] === 1'bx) ? prev : smp;
`endif
  endfunction

  initial begin
    byte_done = 1'b0;
    byte_rx   = 8'h00;
  end

  always @(negedge clk) begin
    logic [7:0] ex, ey;
    byte_done = 1'b0;
    if (rst) begin
      busy = 0;
      idx  = 0;
    end else begin
      if (busy && !byte_req) busy = 0;
      if (csn && !busy) idx = 0;
      if (!busy && byte_req) begin
        busy      = 1;
        done_sent = 0;
        cur_tx    = byte_tx;
        obs_tx.push_back(byte_tx);
        if (idx == 0) first_tx = byte_tx;
        cnt = lat;
        if (stall_arm && byte_tx == 8'h08) begin
          cnt = 100; stall_arm = 0; stalling = 1;
        end
        rsp = (idx == 2) ? rx_x : (idx == 3) ? rx_y : 8'h5A;
        if (idx == 2) smp_x = rx_x;
        if (idx == 3 && first_tx == 8'h0B) begin
          ex = model_pub(m_px, smp_x, m_have);
          ey = model_pub(m_py, rx_y, m_have);
          m_px = ex; m_py = ey; m_have = 1;
          exp_q.push_back({ex, ey});
        end
        idx++;
      end
      if (busy && byte_req && !done_sent) begin
        chk("tx_hold", 32'(byte_tx), 32'(cur_tx));
        if (cnt <= 1) begin
          byte_done = 1'b1; byte_rx = rsp; done_sent = 1; stalling = 0;
        end else begin
          cnt--;
        end
      end else if (spur_arm && !busy && !byte_req && csn) begin
        byte_done = 1'b1; byte_rx = 8'hEE; spur_arm = 0;
      end
    end
  end

  // Scoreboard monitor: every data_valid pops one expected X/Y pair.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && dv) begin
      dv_count++;
      chk("dv_width", 32'(dv_prev), 32'd0);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_x", 32'(ax), 32'(e[15:8]));
        chk("sb_y", 32'(ay), 32'(e[7:0]));
      end
    end
    dv_prev = dv;
  end

  task automatic wait_csn_low(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (csn !== 1'b0 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, "_seen"}, 32'(csn), 32'd0);
  endtask

  task automatic wait_csn_low_neg(input string tag, input int budget);
    int c = 0;
    while (csn !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_seen"}, 32'(csn), 32'd0);
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int c = 0;
    @(negedge clk);
    while (dv !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(dv), 32'd1);
  endtask

  task automatic wait_init(input string tag, input int budget);
    int c = 0;
    while (init_done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(init_done), 32'd1);
  endtask

  task automatic expect_txn(input string tag, input int n, input logic [31:0] bytes);
    int c = 0;
    logic [7:0] b;
    while (obs_tx.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_len"}, 32'(obs_tx.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (obs_tx.size() > 0) begin
        b = obs_tx.pop_front();
        chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(bytes[31 - 8*i -: 8]));
      end
    end
  endtask

  initial begin
    int c, g, falls, last_t, max_int, t;
    logic last_csn;

    rst = 1'b1; lat = 3; rx_x = 8'h11; rx_y = 8'h22;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",  32'(byte_req), 32'd0);
    chk("rst_tx",   32'(byte_tx),  32'd0);
    chk("rst_csn",  32'(csn),      32'd1);
    chk("rst_x",    32'(ax),       32'd0);
    chk("rst_y",    32'(ay),       32'd0);
    chk("rst_dv",   32'(dv),       32'd0);
    chk("rst_init", 32'(init_done), 32'd0);
    obs_tx.delete(); exp_q.delete(); m_have = 0;
    rst = 1'b0;

    // Power-up write
    wait_csn_low("csn_fall", 100, c);
    chk("csn_fall_cycle", 32'(c), 32'(INIT_DELAY));
    chk("csn_lead_req", 32'(byte_req), 32'd0);
    @(posedge clk); #1;
    chk("first_req", 32'(byte_req), 32'd1);
    expect_txn("init_tx", 3, 32'h0A2D_0200);
    wait_init("init_done", 200);
    chk("csn_after_init", 32'(csn), 32'd1);
    g = 0;
    while (csn === 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("cs_gap_min", 32'(g >= CS_GAP), 32'd1);

    // First read
    obs_tx.delete();
    expect_txn("rd_tx", 4, 32'h0B08_0000);
    wait_dv("rd_dv", 200);
    chk("rd_x", 32'(ax), 32'h11);
    chk("rd_y", 32'(ay), 32'h22);
    @(negedge clk);
    chk("rd_dv_pulse", 32'(dv), 32'd0);

    // Spurious done while byte_req is low during GAP
    lat = 1;
    wait_dv("pre_spur_dv", 200);
    spur_arm = 1;
    rx_x = 8'h33; rx_y = 8'h44;
    repeat (3) begin
      @(negedge clk);
      chk("spur_no_dv", 32'(dv), 32'd0);
    end
    chk("spur_x",   32'(ax),  32'h11);
    chk("spur_y",   32'(ay),  32'h22);
    chk("spur_csn", 32'(csn), 32'd1);
    wait_csn_low_neg("post_spur", 100);
    obs_tx.delete();
    expect_txn("post_spur_tx", 4, 32'h0B08_0000);
    wait_dv("post_spur_dv", 200);
    chk("post_spur_x", 32'(ax), 32'h33);
    chk("post_spur_y", 32'(ay), 32'h44);

    // Stall on R_ADDR: byte held, and ticks during the stall do not queue reads
    stall_arm = 1;
    c = 0;
    while (!stalling && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("stall_seen", 32'(stalling), 32'd1);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      chk("stall_tx",  32'(byte_tx),  32'h08);
      chk("stall_req", 32'(byte_req), 32'd1);
    end
    wait_dv("stall_dv", 300);
    falls = 0; last_t = 0; max_int = 0; t = 0; last_csn = csn;
    while (falls < 9 && t < 600) begin
      @(negedge clk);
      t++;
      if (last_csn === 1'b1 && csn === 1'b0) begin
        if (falls > 0 && (t - last_t) > max_int) max_int = t - last_t;
        last_t = t;
        falls++;
      end
      last_csn = csn;
    end
    chk("post_stall_reads", 32'(falls), 32'd9);
    chk("no_queued_reads", 32'(max_int > 13), 32'd1);

    // Reset during R_X, then full re-init
    lat = 3;
    c = 0;
    while (!(busy && idx == 3 && first_tx == 8'h0B && !done_sent) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("in_rx_seen", 32'(busy && idx == 3), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_csn",  32'(csn),       32'd1);
    chk("mrst_req",  32'(byte_req),  32'd0);
    chk("mrst_tx",   32'(byte_tx),   32'd0);
    chk("mrst_x",    32'(ax),        32'd0);
    chk("mrst_y",    32'(ay),        32'd0);
    chk("mrst_dv",   32'(dv),        32'd0);
    chk("mrst_init", 32'(init_done), 32'd0);
    exp_q.delete(); m_have = 0; m_px = 8'h00; m_py = 8'h00;
    rx_x = 8'h10; rx_y = 8'h05;
    repeat (2) @(negedge clk);
    obs_tx.delete();
    rst = 1'b0;
    wait_csn_low("re_csn_fall", 100, c);
    chk("re_csn_fall_cycle", 32'(c), 32'(INIT_DELAY));
    expect_txn("re_init_tx", 3, 32'h0A2D_0200);
    wait_init("re_init_done", 200);

    // Two samples: raw first, then averaged when enabled
    wait_dv("avg1_dv", 300);
    chk("avg1_x", 32'(ax), 32'h10);
    chk("avg1_y", 32'(ay), 32'h05);
    rx_x = 8'h21; rx_y = 8'h07;
    wait_dv("avg2_dv", 300);
`ifdef ACCEL_SEQ_AVG_EN
    chk("avg2_x", 32'(ax), 32'h18);
    chk("avg2_y", 32'(ay), 32'h06);
`else
    chk("avg2_x", 32'(ax), 32'h21);
    chk("avg2_y", 32'(ay), 32'h07);
`endif
    chk("init_held", 32'(init_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
